// File: rtl/rd_fwft_stage.sv
// First-word-fall-through adapter: turns a 1-cycle-latency FIFO memory read
// into a valid/ready stream through a 2-entry in-order output buffer.
module rd_fwft_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic                  r_clk,
    input  logic                  rrst,
    input  logic                  f_empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  r_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            buf_cnt
);

    // ADDR_WIDTH is carried only so the block drops in beside the read-pointer logic.
    if (ADDR_WIDTH == 0) begin : g_no_addr_bits
    end

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  inflight_q, inflight_d;

    logic       pop;
    logic [1:0] occ;
    logic [1:0] occ_after_pop;
    logic [1:0] cnt_after_pop;

    assign m_valid = (cnt_q != 2'd0);
    assign m_data  = head_q;
    assign buf_cnt = cnt_q;

    always_comb begin
        pop           = m_valid & m_ready;
        occ           = cnt_q + {1'b0, inflight_q};
        occ_after_pop = occ - {1'b0, pop};
        r_en          = rrst & ~f_empty & (occ_after_pop < 2'd2);
        inflight_d    = r_en;

        cnt_after_pop = cnt_q - {1'b0, pop};
        cnt_d         = cnt_after_pop + {1'b0, inflight_q};

        head_d = pop ? tail_q : head_q;
        tail_d = tail_q;
        // Returning word lands in the first free slot after this cycle's pop;
        // occ <= 2 guarantees that slot exists.
        if (inflight_q) begin
            if (cnt_after_pop == 2'd0) begin
                head_d = rdata;
            end else begin
                tail_d = rdata;
            end
        end
    end

    always_ff @(posedge r_clk or negedge rrst) begin
        if (!rrst) begin
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_rd_fwft_stage.sv
// Directed bench for rd_fwft_stage: reset, streaming, backpressure, empty edge,
// toggled handshake with order scoreboard, and reset mid-stream.
module tb_rd_fwft_stage;

    localparam int DW = 32;
    localparam logic [DW-1:0] JUNK = 32'hBAD0_BAD0;

    logic          r_clk = 1'b0;
    logic          rrst;
    logic          f_empty;
    logic [DW-1:0] rdata;
    logic          r_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    buf_cnt;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] src_next = '0;
    logic [DW-1:0] exp_word;
    logic [DW-1:0] base;

    always #5 r_clk = ~r_clk;

    rd_fwft_stage #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(9)
    ) dut (
        .r_clk  (r_clk),
        .rrst   (rrst),
        .f_empty(f_empty),
        .rdata  (rdata),
        .r_en   (r_en),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .buf_cnt(buf_cnt)
    );

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; the FIFO model returns the next source word one
    // cycle after r_en was high, junk otherwise.
    task automatic tick();
        logic took;
        took = r_en;
        @(posedge r_clk);
        #1;
        if (took === 1'b1) begin
            rdata = src_next;
            src_next++;
        end else begin
            rdata = JUNK;
        end
    endtask

    initial begin
        rrst    = 1'b1;
        f_empty = 1'b0;
        m_ready = 1'b1;
        rdata   = JUNK;
        #1 rrst = 1'b0;
        #1;

        // Reset held for 10 cycles with data available
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("rst_r_en", r_en, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_buf_cnt", buf_cnt, 0);
            chk("rst_m_data", m_data, 0);
            tick();
        end
        rrst = 1'b1;
        #1;
        chk("rel_r_en", r_en, 1);
        chk("rel_m_valid", m_valid, 0);
        tick();

        // Streaming 0..99
        #1;
        chk("stream_lat_r_en", r_en, 1);
        chk("stream_lat_m_valid", m_valid, 0);
        chk("stream_lat_buf_cnt", buf_cnt, 0);
        tick();
        for (int k = 0; k < 100; k++) begin
            f_empty = (k >= 98);
            #1;
            chk("stream_m_valid", m_valid, 1);
            chk("stream_m_data", m_data, k);
            chk("stream_r_en", r_en, (k < 98));
            tick();
        end
        #1;
        chk("stream_end_m_valid", m_valid, 0);
        chk("stream_end_buf_cnt", buf_cnt, 0);

        // Backpressure: words 100, 101
        m_ready = 1'b0;
        f_empty = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk("bp_r_en", r_en, (c < 2));
            chk("bp_buf_cnt", buf_cnt, (c < 2) ? 0 : ((c == 2) ? 1 : 2));
            chk("bp_m_valid", m_valid, (c >= 2));
            if (c >= 2) chk("bp_m_data_hold", m_data, 100);
            tick();
        end
        m_ready = 1'b1;
        f_empty = 1'b1;
        #1;
        chk("bp_rel_m_data0", m_data, 100);
        chk("bp_rel_r_en", r_en, 0);
        chk("bp_rel_buf_cnt", buf_cnt, 2);
        tick();
        #1;
        chk("bp_rel_m_valid1", m_valid, 1);
        chk("bp_rel_m_data1", m_data, 101);
        chk("bp_rel_buf_cnt1", buf_cnt, 1);
        tick();
        #1;
        chk("bp_drained", m_valid, 0);

        // Empty edge: single word 102, f_empty rises while it is in flight
        f_empty = 1'b0;
        #1;
        chk("edge_r_en", r_en, 1);
        tick();
        f_empty = 1'b1;
        #1;
        chk("edge_r_en_empty", r_en, 0);
        chk("edge_m_valid0", m_valid, 0);
        tick();
        #1;
        chk("edge_m_valid1", m_valid, 1);
        chk("edge_m_data", m_data, 102);
        chk("edge_r_en_empty2", r_en, 0);
        tick();
        #1;
        chk("edge_done_m_valid", m_valid, 0);
        chk("edge_done_buf_cnt", buf_cnt, 0);

        // Toggling handshake with scoreboard
        exp_word = src_next;
        for (int i = 0; i < 48; i++) begin
            m_ready = (i % 2 == 0);
            f_empty = (i % 3 == 1);
            #1;
            chk("tog_cnt_le2", (buf_cnt <= 2'd2), 1);
            chk("tog_no_underflow", (r_en & f_empty), 0);
            if (m_valid && m_ready) begin
                chk("tog_order", m_data, exp_word);
                exp_word++;
            end
            tick();
        end
        f_empty = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("drain_no_underflow", r_en, 0);
            if (m_valid) begin
                chk("drain_order", m_data, exp_word);
                exp_word++;
            end
            tick();
        end
        #1;
        chk("tog_all_delivered", exp_word, src_next);
        chk("tog_final_buf_cnt", buf_cnt, 0);

        // Reset mid-stream with a buffered word and a read in flight
        m_ready = 1'b0;
        f_empty = 1'b0;
        base    = src_next;
        #1;
        chk("mid_r_en0", r_en, 1);
        tick();
        #1;
        chk("mid_r_en1", r_en, 1);
        tick();
        #1;
        chk("mid_buf_cnt", buf_cnt, 1);
        chk("mid_m_data", m_data, base);
        chk("mid_r_en_full", r_en, 0);
        #1 rrst = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_buf_cnt", buf_cnt, 0);
        chk("mid_rst_r_en", r_en, 0);
        chk("mid_rst_m_data", m_data, 0);
        tick();
        tick();
        f_empty = 1'b1;
        m_ready = 1'b1;
        rrst    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_m_valid", m_valid, 0);
            chk("post_rst_r_en", r_en, 0);
            tick();
        end
        f_empty = 1'b0;
        #1;
        chk("post_rst_new_r_en", r_en, 1);
        tick();
        f_empty = 1'b1;
        #1;
        chk("post_rst_wait", m_valid, 0);
        tick();
        #1;
        chk("post_rst_m_valid1", m_valid, 1);
        chk("post_rst_m_data", m_data, base + 2);
        tick();
        #1;
        chk("post_rst_done", m_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
